pc_fetch_unit: RTL and testbench

Owns the program counter and the instruction-fetch handshake for the MIPS core. It drives `pc` to the PC+4 adder and takes `pc4` back as the sequential next address. It issues requests to instruction memory and keeps a one-entry instruction buffer for decode. It also applies branch/jump redirects from decode and honours hazard stalls.

---
 rtl/pc_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch handshake with a one-entry decode buffer
//
// Optional feature macro: FETCH_ALIGN_EXC_EN
//   defined   -> a redirect to a non-word-aligned target is turned into a fetch
//                exception: pc <- EXC_VECTOR, exc_valid_o pulses, exc_badaddr_o
//                records the target.
//   undefined -> target bits [1:0] are cleared, exc_valid_o/exc_badaddr_o stay 0.
//
// Ports:
//   clk                 sole clock, rising edge
//   rst_n               asynchronous active-low reset
//   pc_o                current fetch PC (registered), drives the external PC+4 adder
//   pc4_i               adder result, pc_o + 4 (wraps modulo 2^32)
//   stall_i             decode cannot accept instr_o this cycle
//   redirect_i          branch taken / jump pulse from decode
//   redirect_target_i   new PC when redirect_i is high
//   imem_req_o          fetch request valid (combinational)
//   imem_addr_o         fetch address, always equal to pc_o
//   imem_ready_i        memory returns imem_rdata_i this cycle
//   imem_rdata_i        fetched word
//   instr_o             buffered instruction for decode
//   instr_pc_o          PC of instr_o
//   instr_valid_o       buffer holds a live instruction
//   exc_valid_o         one-cycle misaligned-redirect pulse
//   exc_badaddr_o       offending redirect target
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef FETCH_ALIGN_EXC_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] pc4_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  output logic        exc_valid_o,
  output logic [31:0] exc_badaddr_o
);
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] bad_q, bad_d;
  logic        valid_q, valid_d;
  logic        pend_q, pend_d;
  logic        exc_q, exc_d;
  logic        req;
  logic        misal;
  logic [31:0] tgt;
`ifdef FETCH_ALIGN_EXC_EN
  assign misal = |redirect_target_i[1:0];
  assign tgt   = misal ? EXC_VECTOR : redirect_target_i;
`else
  assign misal = 1'b0;
  assign tgt   = redirect_target_i & ~32'h3;
`endif
  // A raised request stays up until accepted (pend_q); a new one is raised only
  // when the buffer is empty or drained this cycle. FLUSH always has one in flight.
  assign req = (state_q == FLUSH) ||
               (state_q == FETCH && (pend_q || !valid_q || !stall_i));
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    tgt_d   = tgt_q;
    bad_d   = bad_q;
    exc_d   = 1'b0;
    pend_d  = req && !imem_ready_i;
    if (state_q != IDLE && redirect_i) begin
      exc_d = misal;
      bad_d = misal ? redirect_target_i : bad_q;
    end
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (redirect_i) begin
          valid_d = 1'b0;
          // an unanswered request cannot be withdrawn, so park the target until it returns
          if (pend_d) begin
            tgt_d   = tgt;
            state_d = FLUSH;
          end else begin
            pc_d = tgt;
          end
        end else if (req && imem_ready_i) begin
          instr_d = imem_rdata_i;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc4_i;
        end else if (!stall_i) begin
          valid_d = 1'b0;
        end
      end
      FLUSH: begin
        tgt_d = redirect_i ? tgt : tgt_q;
        if (imem_ready_i) begin
          pc_d    = redirect_i ? tgt : tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
      exc_q   <= 1'b0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      exc_q   <= exc_d;
      bad_q   <= bad_d;
    end
  end
  assign pc_o          = pc_q;
  assign imem_req_o    = req;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign instr_valid_o = valid_q;
  assign exc_valid_o   = exc_q;
  assign exc_badaddr_o = bad_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized and directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_o, pc4_i;
  logic        stall_i = 1'b0, redirect_i = 1'b0, imem_ready_i = 1'b0;
  logic [31:0] redirect_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o, imem_rdata_i, instr_o, instr_pc_o, exc_badaddr_o;
  logic        instr_valid_o, exc_valid_o;
  int n_cmp = 0, n_fail = 0;
  // reference model: fetch pointer, outstanding/discard flags, and a queue for the decode buffer
  logic [31:0] m_pc = RST_PC, m_tgt = '0, m_bad = '0, m_lpc = '0, m_ldat = '0;
  logic        m_run = 1'b0, m_out = 1'b0, m_drop = 1'b0, m_exc = 1'b0;
  logic [63:0] m_buf[$];
  logic        obs_req, exp_req;
  logic [31:0] obs_addr, exp_addr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  assign pc4_i        = pc_o + 32'd4;
  assign imem_rdata_i = mem(imem_addr_o);

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .pc4_i(pc4_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_rdata_i(imem_rdata_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_valid_o(instr_valid_o), .exc_valid_o(exc_valid_o), .exc_badaddr_o(exc_badaddr_o)
  );

  task automatic model_reset();
    m_pc = RST_PC; m_tgt = '0; m_bad = '0; m_lpc = '0; m_ldat = '0;
    m_run = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_exc = 1'b0;
    m_buf.delete();
  endtask

  // one clock: drive inputs at the falling edge, capture the combinational
  // request, advance the model, return just after the rising edge
  task automatic drive(input logic s, input logic r, input logic [31:0] t, input logic rd);
    logic [31:0] eff;
    logic done;
    @(negedge clk);
    stall_i = s; redirect_i = r; redirect_target_i = t; imem_ready_i = rd;
    #1;
    obs_req  = imem_req_o;
    obs_addr = imem_addr_o;
    exp_req  = m_run && (m_out || m_buf.size() == 0 || !s);
    exp_addr = m_pc;
    done     = exp_req && rd;
    m_exc    = 1'b0;
    if (!m_run) begin
      m_run = 1'b1;
    end else if (r) begin
      eff = t & ~32'h3;
`ifdef FETCH_ALIGN_EXC_EN
      eff = t;
      if (t[1:0] != 2'b00) begin
        eff = EXC_PC; m_exc = 1'b1; m_bad = t;
      end
`endif
      m_buf.delete();
      if (exp_req && !done) begin
        m_drop = 1'b1; m_out = 1'b1; m_tgt = eff;
      end else begin
        m_drop = 1'b0; m_out = 1'b0; m_pc = eff;
      end
    end else if (done) begin
      m_out = 1'b0;
      if (m_drop) begin
        m_drop = 1'b0; m_pc = m_tgt;
      end else begin
        m_buf.delete();
        m_buf.push_back({m_pc, mem(m_pc)});
        m_lpc = m_pc; m_ldat = mem(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end else begin
      m_out = exp_req;
      if (!s && m_buf.size() != 0) m_buf.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (pc_o !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_o, RST_PC); end
    n_cmp++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr_o); end
    n_cmp++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc_o); end
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    n_cmp++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    n_cmp++; if (exc_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b want 0", exc_valid_o); end
    n_cmp++; if (exc_badaddr_o !== 32'h0) begin n_fail++; $display("FAIL reset_badaddr: got %h want 0", exc_badaddr_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    drive(0, 0, 0, 1);
    n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got %b want 0", obs_req); end
    for (int i = 0; i < 3; i++) begin
      a = RST_PC + 32'(4 * i);
      drive(0, 0, 0, 1);
      n_cmp++; if (obs_req !== 1'b1 || obs_addr !== a) begin n_fail++; $display("FAIL zw_addr%0d: got req=%b addr=%h want req=1 addr=%h", i, obs_req, obs_addr, a); end
      n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== a || instr_o !== mem(a)) begin n_fail++; $display("FAIL zw_instr%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", i, instr_valid_o, instr_pc_o, instr_o, a, mem(a)); end
    end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, (i == 2));
      n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h300C) begin n_fail++; $display("FAIL lat_hold%0d: got req=%b addr=%h want req=1 addr=300c", i, obs_req, obs_addr); end
      n_cmp++; if (instr_valid_o !== (i == 2)) begin n_fail++; $display("FAIL lat_valid%0d: got %b want %b", i, instr_valid_o, (i == 2)); end
    end
    n_cmp++; if (instr_pc_o !== 32'h300C) begin n_fail++; $display("FAIL lat_instr_pc: got %h want 300c", instr_pc_o); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1);
      n_cmp++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL stall_full_req%0d: got %b want 0", i, obs_req); end
      n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h300C || instr_o !== mem(32'h300C)) begin n_fail++; $display("FAIL stall_hold%0d: got v=%b pc=%h want v=1 pc=300c", i, instr_valid_o, instr_pc_o); end
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, (i == 3));
      n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h3010) begin n_fail++; $display("FAIL stall_outstanding%0d: got req=%b addr=%h want req=1 addr=3010", i, obs_req, obs_addr); end
    end
    n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h3010) begin n_fail++; $display("FAIL stall_deliver: got v=%b pc=%h want v=1 pc=3010", instr_valid_o, instr_pc_o); end
    drive(1, 0, 0, 1);
    n_cmp++; if (obs_req !== 1'b0 || instr_pc_o !== 32'h3010) begin n_fail++; $display("FAIL stall_no_new_req: got req=%b pc=%h want req=0 pc=3010", obs_req, instr_pc_o); end
    drive(0, 0, 0, 1);
    n_cmp++; if (instr_pc_o !== 32'h3014 || pc_o !== 32'h3018) begin n_fail++; $display("FAIL stall_release: got ipc=%h pc=%h want 3014/3018", instr_pc_o, pc_o); end
  endtask

  task automatic test_redirect();
    drive(0, 0, 0, 0);
    drive(0, 1, 32'h3100, 0);
    n_cmp++; if (instr_valid_o !== 1'b0 || pc_o !== 32'h3018) begin n_fail++; $display("FAIL flush_enter: got v=%b pc=%h want v=0 pc=3018", instr_valid_o, pc_o); end
    drive(0, 0, 0, 0);
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 32'h3018) begin n_fail++; $display("FAIL flush_hold: got req=%b addr=%h want req=1 addr=3018", obs_req, obs_addr); end
    drive(0, 0, 0, 1);
    n_cmp++; if (instr_valid_o !== 1'b0 || pc_o !== 32'h3100) begin n_fail++; $display("FAIL flush_discard: got v=%b pc=%h want v=0 pc=3100", instr_valid_o, pc_o); end
    drive(0, 0, 0, 1);
    n_cmp++; if (obs_addr !== 32'h3100 || instr_pc_o !== 32'h3100 || instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL redirect_first: got addr=%h ipc=%h v=%b want 3100/3100/1", obs_addr, instr_pc_o, instr_valid_o); end
    drive(0, 1, 32'h3200, 1);
    n_cmp++; if (instr_valid_o !== 1'b0 || pc_o !== 32'h3200) begin n_fail++; $display("FAIL redirect_with_ready: got v=%b pc=%h want v=0 pc=3200", instr_valid_o, pc_o); end
    drive(0, 0, 0, 1);
    drive(1, 1, 32'h3300, 1);
    n_cmp++; if (obs_req !== 1'b0 || instr_valid_o !== 1'b0 || pc_o !== 32'h3300) begin n_fail++; $display("FAIL redirect_over_stall: got req=%b v=%b pc=%h want 0/0/3300", obs_req, instr_valid_o, pc_o); end
    drive(0, 0, 0, 0);
    drive(0, 1, 32'h3400, 0);
    drive(0, 1, 32'h3500, 0);
    drive(0, 0, 0, 1);
    n_cmp++; if (pc_o !== 32'h3500) begin n_fail++; $display("FAIL flush_overwrite: got pc=%h want 3500", pc_o); end
  endtask

  task automatic test_wrap();
    drive(0, 1, 32'hFFFF_FFFC, 1);
    drive(0, 0, 0, 1);
    n_cmp++; if (pc_o !== 32'h0 || instr_pc_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap: got pc=%h ipc=%h want 0/fffffffc", pc_o, instr_pc_o); end
  endtask

  task automatic test_misalign();
    logic [31:0] want_pc, want_bad;
    logic want_exc;
`ifdef FETCH_ALIGN_EXC_EN
    want_pc = EXC_PC; want_exc = 1'b1; want_bad = 32'h3102;
`else
    want_pc = 32'h3100; want_exc = 1'b0; want_bad = 32'h0;
`endif
    drive(0, 1, 32'h3102, 1);
    n_cmp++; if (exc_valid_o !== want_exc || exc_badaddr_o !== want_bad || pc_o !== want_pc) begin n_fail++; $display("FAIL misalign: got exc=%b bad=%h pc=%h want %b/%h/%h", exc_valid_o, exc_badaddr_o, pc_o, want_exc, want_bad, want_pc); end
    drive(0, 0, 0, 1);
    n_cmp++; if (obs_addr !== want_pc || exc_valid_o !== 1'b0) begin n_fail++; $display("FAIL misalign_next: got addr=%h exc=%b want %h/0", obs_addr, exc_valid_o, want_pc); end
  endtask

  task automatic test_random();
    logic p_req = 1'b0, p_rdy = 1'b0;
    logic [31:0] p_addr = '0, t;
    for (int i = 0; i < 800; i++) begin
      t = ($urandom & 32'h0000_FFFC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t, $urandom_range(0, 1) == 1);
      n_cmp++; if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin n_fail++; $display("FAIL rnd_req@%0d: got req=%b addr=%h want req=%b addr=%h", i, obs_req, obs_addr, exp_req, exp_addr); end
      if (p_req && !p_rdy) begin
        n_cmp++; if (obs_req !== 1'b1 || obs_addr !== p_addr) begin n_fail++; $display("FAIL rnd_hold@%0d: got req=%b addr=%h want req=1 addr=%h", i, obs_req, obs_addr, p_addr); end
      end
      p_req = obs_req; p_rdy = imem_ready_i; p_addr = obs_addr;
      n_cmp++; if (pc_o !== m_pc) begin n_fail++; $display("FAIL rnd_pc@%0d: got %h want %h", i, pc_o, m_pc); end
      n_cmp++; if (instr_valid_o !== (m_buf.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, instr_valid_o, m_buf.size() != 0); end
      if (m_buf.size() != 0) begin
        n_cmp++; if (instr_pc_o !== m_lpc || instr_o !== m_ldat) begin n_fail++; $display("FAIL rnd_instr@%0d: got pc=%h d=%h want pc=%h d=%h", i, instr_pc_o, instr_o, m_lpc, m_ldat); end
      end
      n_cmp++; if (exc_valid_o !== m_exc || exc_badaddr_o !== m_bad) begin n_fail++; $display("FAIL rnd_exc@%0d: got %b/%h want %b/%h", i, exc_valid_o, exc_badaddr_o, m_exc, m_bad); end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 0);
    @(negedge clk);
    stall_i = 1'b0; redirect_i = 1'b0; imem_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (pc_o !== RST_PC || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid: got pc=%h req=%b v=%b want 3000/0/0", pc_o, imem_req_o, instr_valid_o); end
    imem_ready_i = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 1);
    n_cmp++; if (obs_req !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_late_ready: got req=%b v=%b want 0/0", obs_req, instr_valid_o); end
    drive(0, 0, 0, 1);
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== RST_PC || instr_pc_o !== RST_PC) begin n_fail++; $display("FAIL reset_restart: got req=%b addr=%h ipc=%h want 1/3000/3000", obs_req, obs_addr, instr_pc_o); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
